mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters of the multicycle CPU: the fetch path (I port) and the load/store path (D port).
- Serialises accesses and handles variable memory latency through MEM_READY.
- Returns read data with a one-cycle acknowledge pulse.
- Flags memories that never respond, via a timeout.

Parameters:
- AW, 12, byte-address width on all ports.
- DW, 32, data width (fixed at 32 for this CPU; BE is 4 bits).
- TIMEOUT, 15, maximum number of access cycles to wait for MEM_READY before aborting (1..255).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- I_REQ  in  1  fetch request; held high until I_ACK.
- I_ADDR  in  AW  fetch byte address.
- I_RDATA  out  DW  fetched word, registered.
- I_ACK  out  1  one-cycle completion pulse.
- D_REQ  in  1  data request; held high until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_BE  in  4  byte-lane enables.
- D_ADDR  in  AW  data byte address.
- D_WDATA  in  DW  store data.
- D_RDATA  out  DW  load data, registered.
- D_ACK  out  1  one-cycle completion pulse.
- MEM_CSN  out  1  memory chip select, active low.
- MEM_WEN  out  1  memory write enable, active low.
- MEM_BE  out  4  memory byte enables.
- MEM_ADDR  out  AW  word-aligned address; bits [1:0] are forced to 0.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data; valid when MEM_READY = 1.
- MEM_READY  in  1  memory access complete.
- ERR  out  1  high together with the ACK of an access that timed out.

Behaviour:
- Reset (asynchronous, effective at any time including mid-access):
  - Output values: MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, I_RDATA=0, D_RDATA=0, I_ACK=0, D_ACK=0, ERR=0.
  - Internal state: state=IDLE, wait counter=0, last_grant=I.
  - An in-flight access is abandoned with no ACK.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Samples I_REQ and D_REQ. With neither asserted, stays in IDLE.
  - One request asserted: that requester is granted.
  - Both asserted: the requester that is not last_grant wins. After reset D wins the first tie; grants alternate on sustained contention.
  - On grant, latch the grant owner and load the memory outputs, then go to ACCESS:
    - I grant: MEM_WEN=1, MEM_BE=4'b1111, MEM_ADDR={I_ADDR[AW-1:2],2'b00}.
    - D grant: MEM_WEN=~D_WE, MEM_BE=D_BE, MEM_ADDR aligned D_ADDR, MEM_WDATA=D_WDATA.
  - Special case D_BE==4'b0000: no memory cycle. MEM_CSN stays 1, go directly to RESP with ACK and D_RDATA unchanged.
- ACCESS:
  - MEM_CSN=0 and all memory outputs are held stable.
  - MEM_READY=1 sampled:
    - For a read, capture MEM_RDATA into the owner's RDATA register.
    - Deassert MEM_CSN and MEM_WEN and go to RESP.
    - Stores leave D_RDATA unchanged.
  - MEM_READY=0: increment the wait counter.
  - Wait counter reaches TIMEOUT-1 with MEM_READY still 0:
    - Deassert MEM_CSN and go to RESP with ERR pending.
    - The owner's RDATA is set to 0.
- RESP:
  - Owner's ACK=1 for exactly one cycle. ERR=1 only if timed out.
  - Update last_grant to the owner, clear the wait counter, return to IDLE.
- Latency: REQ seen in IDLE at cycle 0; memory driven in cycles 1..n; ACK in cycle n+1. Minimum latency is ACK in cycle 2, with MEM_READY high on the first ACCESS cycle.
- Requester rules:
  - REQ and its address/data must stay stable until ACK.
  - REQ must be low in the cycle after ACK; a REQ still high in IDLE is treated as a new request.
  - A REQ dropped mid-access does not abort the access; the ACK still pulses.
- Non-owner REQ during ACCESS/RESP is ignored until the next IDLE. No requester is starved: under continuous contention the wait is at most one access.
- ACK of the non-owner is never asserted. I_ACK and D_ACK are mutually exclusive.

Test Plan:
- Single fetch: I_ADDR=0x104, MEM_READY high at the first ACCESS cycle, MEM_RDATA=0x00500093 -> MEM_ADDR=0x104 and MEM_BE=1111 in cycle 1; I_ACK in cycle 2; I_RDATA=0x00500093; ERR=0.
- Store byte with 3 wait cycles: D_WE=1, D_BE=0001, D_ADDR=0x203, D_WDATA=0xAB -> MEM_ADDR=0x200 and MEM_WEN=0 held for 4 cycles; D_ACK in cycle 5; D_RDATA unchanged.
- Simultaneous I_REQ and D_REQ after reset, both held with immediate READY -> D served first, then I, then D again; grants alternate; ACKs never overlap.
- MEM_READY tied 0 with TIMEOUT=15 on a load -> CSN low for exactly 15 cycles; D_ACK=1 and ERR=1 in the following cycle; D_RDATA=0; then back to IDLE.
- D_BE=0000 load -> MEM_CSN never asserted; D_ACK in cycle 1; D_RDATA keeps its previous value.
- RSTn pulsed low during ACCESS -> MEM_CSN=1 and all outputs at reset values immediately; no ACK issued; the next tie is won by D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// path (I port) and the load/store path (D port) of the multicycle CPU.
// Accesses are serialised, memory latency is absorbed through MEM_READY, and
// a memory that never answers is aborted after TIMEOUT access cycles with ERR
// raised alongside the owner's ACK.
//
// Parameters
//   AW       byte-address width on all ports
//   DW       data width (32; byte enables are 4 bits)
//   TIMEOUT  access cycles to wait for MEM_READY before aborting (1..255)
//
// Ports
//   CLK, RSTn                      clock (rising edge), async active-low reset
//   I_REQ, I_ADDR                  fetch request and byte address
//   I_RDATA, I_ACK                 fetched word, one-cycle completion pulse
//   D_REQ, D_WE, D_BE, D_ADDR,     load/store request, write flag, byte lanes,
//   D_WDATA                        byte address and store data
//   D_RDATA, D_ACK                 load data, one-cycle completion pulse
//   MEM_CSN, MEM_WEN, MEM_BE,      memory strobes (active low), byte enables,
//   MEM_ADDR, MEM_WDATA            word-aligned address and write data
//   MEM_RDATA, MEM_READY           memory read data and completion
//   ERR                            timeout flag, coincident with the ACK
//
// Every output is a register.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RSTn,
  // fetch port
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic [DW-1:0] I_RDATA,
  output logic          I_ACK,
  // load/store port
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [3:0]    D_BE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic [DW-1:0] D_RDATA,
  output logic          D_ACK,
  // memory side
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [3:0]    MEM_BE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_READY,
  // status
  output logic          ERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Counter value on the last permitted access cycle. The counter starts at 0
  // on the first ACCESS cycle, so comparing against TIMEOUT-1 keeps MEM_CSN
  // low for exactly TIMEOUT cycles when the memory never answers.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  owner_t     owner_reg;
  owner_t     last_grant_reg;
  logic [7:0] wait_cnt_reg;

  // Arbitration decision, only acted on in IDLE. On a tie the requester that
  // did not get the previous grant wins, so neither side waits more than one
  // access under sustained contention.
  logic grant_d;

  always_comb begin
    grant_d = 1'b0;
    if (I_REQ && D_REQ) begin
      grant_d = (last_grant_reg == OWN_I);
    end else begin
      grant_d = D_REQ;
    end
  end

  // Word alignment ignores the two byte-offset bits of both request addresses.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{I_ADDR[1:0], D_ADDR[1:0]};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_I;
      last_grant_reg <= OWN_I;
      wait_cnt_reg   <= 8'd0;
      MEM_CSN        <= 1'b1;
      MEM_WEN        <= 1'b1;
      MEM_BE         <= 4'b0000;
      MEM_ADDR       <= '0;
      MEM_WDATA      <= '0;
      I_RDATA        <= '0;
      D_RDATA        <= '0;
      I_ACK          <= 1'b0;
      D_ACK          <= 1'b0;
      ERR            <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (I_REQ || D_REQ) begin
            if (grant_d) begin
              owner_reg <= OWN_D;
              if (D_BE == 4'b0000) begin
                // Nothing to transfer: skip the memory cycle entirely and
                // acknowledge straight away, leaving D_RDATA untouched.
                D_ACK     <= 1'b1;
                state_reg <= ST_RESP;
              end else begin
                MEM_CSN   <= 1'b0;
                MEM_WEN   <= ~D_WE;
                MEM_BE    <= D_BE;
                MEM_ADDR  <= {D_ADDR[AW-1:2], 2'b00};
                MEM_WDATA <= D_WDATA;
                state_reg <= ST_ACCESS;
              end
            end else begin
              owner_reg <= OWN_I;
              MEM_CSN   <= 1'b0;
              MEM_WEN   <= 1'b1;
              MEM_BE    <= 4'b1111;
              MEM_ADDR  <= {I_ADDR[AW-1:2], 2'b00};
              state_reg <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          if (MEM_READY) begin
            // MEM_WEN high means this access is a read (fetches always are).
            if (MEM_WEN) begin
              if (owner_reg == OWN_D) begin
                D_RDATA <= MEM_RDATA;
              end else begin
                I_RDATA <= MEM_RDATA;
              end
            end
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            I_ACK     <= (owner_reg == OWN_I);
            D_ACK     <= (owner_reg == OWN_D);
            state_reg <= ST_RESP;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            // Memory never answered: abort and hand the owner a zero word.
            if (owner_reg == OWN_D) begin
              D_RDATA <= '0;
            end else begin
              I_RDATA <= '0;
            end
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            ERR       <= 1'b1;
            I_ACK     <= (owner_reg == OWN_I);
            D_ACK     <= (owner_reg == OWN_D);
            state_reg <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        ST_RESP: begin
          I_ACK          <= 1'b0;
          D_ACK          <= 1'b0;
          ERR            <= 1'b0;
          last_grant_reg <= owner_reg;
          wait_cnt_reg   <= 8'd0;
          state_reg      <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
// on the falling clock edge. "Cycle 0" is the cycle whose closing rising edge
// sees the request in IDLE; cycle k is sampled at the k-th falling edge after
// that. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          CLK;
  logic          RSTn;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic [DW-1:0] I_RDATA;
  logic          I_ACK;
  logic          D_REQ;
  logic          D_WE;
  logic [3:0]    D_BE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic [DW-1:0] D_RDATA;
  logic          D_ACK;
  logic          MEM_CSN;
  logic          MEM_WEN;
  logic [3:0]    MEM_BE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_READY;
  logic          ERR;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .I_REQ(I_REQ),
    .I_ADDR(I_ADDR),
    .I_RDATA(I_RDATA),
    .I_ACK(I_ACK),
    .D_REQ(D_REQ),
    .D_WE(D_WE),
    .D_BE(D_BE),
    .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA),
    .D_ACK(D_ACK),
    .MEM_CSN(MEM_CSN),
    .MEM_WEN(MEM_WEN),
    .MEM_BE(MEM_BE),
    .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA),
    .MEM_READY(MEM_READY),
    .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_csn"},   MEM_CSN,   1);
    chk({tag, "_wen"},   MEM_WEN,   1);
    chk({tag, "_be"},    MEM_BE,    0);
    chk({tag, "_addr"},  MEM_ADDR,  0);
    chk({tag, "_wdata"}, MEM_WDATA, 0);
    chk({tag, "_irdat"}, I_RDATA,   0);
    chk({tag, "_drdat"}, D_RDATA,   0);
    chk({tag, "_iack"},  I_ACK,     0);
    chk({tag, "_dack"},  D_ACK,     0);
    chk({tag, "_err"},   ERR,       0);
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic acc;

    RSTn = 1'b0;
    I_REQ = 1'b0; I_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'b0000; D_ADDR = '0; D_WDATA = '0;
    MEM_RDATA = '0; MEM_READY = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    RSTn = 1'b1;
    @(negedge CLK);

    // ---------------- single fetch, zero wait ----------------
    I_REQ = 1'b1; I_ADDR = 12'h104;
    @(negedge CLK);                                   // cycle 1
    chk("f_csn",  MEM_CSN,  0);
    chk("f_wen",  MEM_WEN,  1);
    chk("f_addr", MEM_ADDR, 32'h104);
    chk("f_be",   MEM_BE,   4'b1111);
    chk("f_ack1", I_ACK,    0);
    MEM_READY = 1'b1; MEM_RDATA = 32'h00500093;
    @(negedge CLK);                                   // cycle 2
    chk("f_ack",   I_ACK,   1);
    chk("f_dack",  D_ACK,   0);
    chk("f_rdata", I_RDATA, 32'h00500093);
    chk("f_err",   ERR,     0);
    chk("f_csn2",  MEM_CSN, 1);
    $display("txn fetch addr=%h rdata=%h", I_ADDR, I_RDATA);
    I_REQ = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);
    chk("f_ackpulse", I_ACK, 0);

    // ---------------- load, one wait cycle, unaligned address ----------------
    D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b1111; D_ADDR = 12'h012;
    @(negedge CLK);                                   // cycle 1
    chk("ld_csn",  MEM_CSN,  0);
    chk("ld_wen",  MEM_WEN,  1);
    chk("ld_addr", MEM_ADDR, 32'h010);
    @(negedge CLK);                                   // cycle 2
    chk("ld_csn2", MEM_CSN, 0);
    chk("ld_ack2", D_ACK,   0);
    MEM_READY = 1'b1; MEM_RDATA = 32'h12345678;
    @(negedge CLK);                                   // cycle 3
    chk("ld_ack",   D_ACK,   1);
    chk("ld_iack",  I_ACK,   0);
    chk("ld_rdata", D_RDATA, 32'h12345678);
    chk("ld_irdat", I_RDATA, 32'h00500093);
    $display("txn load addr=%h rdata=%h", D_ADDR, D_RDATA);
    D_REQ = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);

    // ---------------- store byte, three wait cycles ----------------
    D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'b0001; D_ADDR = 12'h203; D_WDATA = 32'h000000AB;
    MEM_RDATA = 32'hFFFFFFFF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      chk("st_csn",   MEM_CSN,   0);
      chk("st_wen",   MEM_WEN,   0);
      chk("st_addr",  MEM_ADDR,  32'h200);
      chk("st_be",    MEM_BE,    4'b0001);
      chk("st_wdata", MEM_WDATA, 32'h000000AB);
      chk("st_ackw",  D_ACK,     0);
      MEM_READY = (c == 4);
    end
    @(negedge CLK);                                   // cycle 5
    chk("st_ack",   D_ACK,   1);
    chk("st_err",   ERR,     0);
    chk("st_csn5",  MEM_CSN, 1);
    chk("st_rdata", D_RDATA, 32'h12345678);
    $display("txn store addr=%h wdata=%h be=%b", D_ADDR, D_WDATA, D_BE);
    D_REQ = 1'b0; D_WE = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);

    // ---------------- zero byte-enable load: no memory cycle ----------------
    D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b0000; D_ADDR = 12'h300;
    @(negedge CLK);                                   // cycle 1
    chk("be0_ack",   D_ACK,   1);
    chk("be0_csn",   MEM_CSN, 1);
    chk("be0_rdata", D_RDATA, 32'h12345678);
    chk("be0_err",   ERR,     0);
    $display("txn be0 addr=%h rdata=%h", D_ADDR, D_RDATA);
    D_REQ = 1'b0;
    @(negedge CLK);
    chk("be0_csn2", MEM_CSN, 1);
    chk("be0_ack2", D_ACK,   0);

    // ---------------- timeout on a load ----------------
    D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b1111; D_ADDR = 12'h3F8;
    MEM_READY = 1'b0; MEM_RDATA = 32'hDEADBEEF;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge CLK);
      chk("to_csn", MEM_CSN, 0);
      chk("to_ack", D_ACK,   0);
      chk("to_err", ERR,     0);
    end
    @(negedge CLK);                                   // cycle TIMEOUT+1
    chk("to_dack",  D_ACK,   1);
    chk("to_errhi", ERR,     1);
    chk("to_csnhi", MEM_CSN, 1);
    chk("to_rdata", D_RDATA, 0);
    chk("to_iack",  I_ACK,   0);
    $display("txn timeout addr=%h rdata=%h err=%b", D_ADDR, D_RDATA, ERR);
    D_REQ = 1'b0;
    @(negedge CLK);
    chk("to_errlo", ERR,   0);
    chk("to_acklo", D_ACK, 0);
    chk("to_idle",  MEM_CSN, 1);

    // ---------------- reset in the middle of an access ----------------
    // last grant is D here, so a post-reset D win proves last_grant was reset.
    D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b1111; D_ADDR = 12'h010;
    @(negedge CLK);                                   // cycle 1
    chk("mr_csn", MEM_CSN, 0);
    RSTn = 1'b0;
    #1;
    check_reset_outputs("mr");
    @(negedge CLK);
    RSTn = 1'b1; D_REQ = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("mr_dack", D_ACK, 0);
      chk("mr_iack", I_ACK, 0);
      chk("mr_csnq", MEM_CSN, 1);
    end
    $display("txn reset mid-access abandoned");

    // ---------------- contention: D, then I, then D ----------------
    I_REQ = 1'b1; I_ADDR = 12'h040;
    D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b1111; D_ADDR = 12'h080;
    MEM_READY = 1'b1; MEM_RDATA = 32'h11110000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      acc = (c == 1) || (c == 4) || (c == 7);
      chk("ct_csn",  MEM_CSN, {31'd0, !acc});
      if (acc) chk("ct_addr", MEM_ADDR, (c == 4) ? 32'h040 : 32'h080);
      chk("ct_dack", D_ACK, {31'd0, (c == 2) || (c == 8)});
      chk("ct_iack", I_ACK, {31'd0, (c == 5)});
      chk("ct_excl", {31'd0, I_ACK & D_ACK}, 0);
      if (c == 2) begin
        chk("ct_d1", D_RDATA, 32'h11110000);
        $display("txn tie grant=D rdata=%h", D_RDATA);
        MEM_RDATA = 32'h22220000;
      end
      if (c == 5) begin
        chk("ct_i1", I_RDATA, 32'h22220000);
        $display("txn tie grant=I rdata=%h", I_RDATA);
        MEM_RDATA = 32'h33330000;
      end
      if (c == 8) begin
        chk("ct_d2", D_RDATA, 32'h33330000);
        $display("txn tie grant=D rdata=%h", D_RDATA);
      end
    end
    I_REQ = 1'b0; D_REQ = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);
    chk("ct_end_d", D_ACK, 0);
    chk("ct_end_i", I_ACK, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
